// File: rtl/apb_slave_bank_if.sv
// APB slave-side bus bundle between the AHB-to-APB bridge and apb_slave_bank.
// Latency: none, wires only.
// Backpressure: none; APB here runs zero-wait-state with no PREADY.
//
// Signals:
//   Pselx   [2:0]  one-hot slave select, bit i selects bank i
//   Penable        ACCESS-phase strobe
//   Pwrite         1 = write, 0 = read
//   Paddr   [31:0] byte address
//   Pwdata  [31:0] write data
//   Prdata  [31:0] registered read data returned by the slave
interface apb_slave_bank_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Pselx,
        output Penable,
        output Pwrite,
        output Paddr,
        output Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx,
        input  Penable,
        input  Pwrite,
        input  Paddr,
        input  Pwdata,
        output Prdata
    );
endinterface

// File: rtl/apb_slave_bank.sv
// Three 32-bit register banks behind APB, with SETUP/ACCESS protocol checking.
// Latency: Prdata registered on the edge ending SETUP, stable through ACCESS.
// Backpressure: none; zero wait states, violations are flagged and counted.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   bus            APB slave modport (Pselx, Penable, Pwrite, Paddr, Pwdata, Prdata)
//   err_clr        synchronous pulse, clears prot_err and err_count
//   prot_err       sticky protocol-violation flag
//   err_count[7:0] saturating violation count
//   xfer_count[15:0] wrapping count of committed transfers
module apb_slave_bank #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    apb_slave_bank_if.slave         bus,
    input  logic                    err_clr,
    output logic                    prot_err,
    output logic [7:0]              err_count,
    output logic [15:0]             xfer_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Transfer attributes captured in SETUP; ACCESS must present the same values.
    logic [2:0]    s_sel_q;
    logic [1:0]    s_bank_q;
    logic [AW-1:0] s_idx_q;
    logic          s_wr_q;
    logic [31:0]   s_wdata_q;

    logic [31:0]   prdata_q;
    logic [31:0]   mem [3][DEPTH];

    logic [AW-1:0] idx;
    logic          sel_ok;
    logic [1:0]    sel_bank;
    logic          setup_req;
    logic          access_match;
    logic          enter_setup;
    logic          commit;
    logic          viol;

    // Region decode is done upstream; only the word index matters here.
    assign idx = bus.Paddr[AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.Paddr[31:AW+2], bus.Paddr[1:0]};

    assign sel_ok = (bus.Pselx == 3'b001) || (bus.Pselx == 3'b010) ||
                    (bus.Pselx == 3'b100);

    always_comb begin
        sel_bank = 2'd0;
        case (bus.Pselx)
            3'b010:  sel_bank = 2'd1;
            3'b100:  sel_bank = 2'd2;
            default: sel_bank = 2'd0;
        endcase
    end

    assign setup_req = sel_ok && !bus.Penable;

    // Write data only has to be held when the transfer is a write.
    assign access_match = bus.Penable &&
                          (bus.Pselx == s_sel_q) &&
                          (idx == s_idx_q) &&
                          (bus.Pwrite == s_wr_q) &&
                          (!s_wr_q || (bus.Pwdata == s_wdata_q));

    always_comb begin
        state_d     = state_q;
        enter_setup = 1'b0;
        commit      = 1'b0;
        viol        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Pselx == 3'b000) begin
                    state_d = ST_IDLE;
                end else if (setup_req) begin
                    state_d     = ST_SETUP;
                    enter_setup = 1'b1;
                end else begin
                    viol = 1'b1;
                end
            end
            ST_SETUP: begin
                if (access_match) begin
                    state_d = ST_ACCESS;
                    commit  = 1'b1;
                end else begin
                    // A broken ACCESS that is itself a clean SETUP restarts the transfer.
                    viol = 1'b1;
                    if (setup_req) begin
                        state_d     = ST_SETUP;
                        enter_setup = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.Pselx == 3'b000 && !bus.Penable) begin
                    state_d = ST_IDLE;
                end else if (setup_req) begin
                    state_d     = ST_SETUP;
                    enter_setup = 1'b1;
                end else begin
                    viol    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_sel_q   <= 3'b000;
            s_bank_q  <= 2'd0;
            s_idx_q   <= '0;
            s_wr_q    <= 1'b0;
            s_wdata_q <= 32'h0;
        end else if (enter_setup) begin
            s_sel_q   <= bus.Pselx;
            s_bank_q  <= sel_bank;
            s_idx_q   <= idx;
            s_wr_q    <= bus.Pwrite;
            s_wdata_q <= bus.Pwdata;
        end
    end

    // Read data is fetched at SETUP so it is already stable for the whole ACCESS cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prdata_q <= 32'h0;
        end else if (enter_setup && !bus.Pwrite) begin
            prdata_q <= mem[sel_bank][idx];
        end
    end

    assign bus.Prdata = prdata_q;

    // Writes land on the commit edge, so a read SETUP in the very next cycle sees them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem[b][w] <= 32'h0;
                end
            end
        end else if (commit && s_wr_q) begin
            mem[s_bank_q][s_idx_q] <= s_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_count <= 16'h0;
        end else if (commit) begin
            xfer_count <= xfer_count + 16'h1;
        end
    end

    // Clear wins over a violation in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prot_err  <= 1'b0;
            err_count <= 8'h0;
        end else if (err_clr) begin
            prot_err  <= 1'b0;
            err_count <= 8'h0;
        end else if (viol) begin
            prot_err <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'h1;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench for apb_slave_bank: expectations are queued with a due cycle
// and a negedge monitor compares them against the DUT outputs.
module tb_apb_slave_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        err_clr = 1'b0;
    logic        prot_err;
    logic [7:0]  err_count;
    logic [15:0] xfer_count;

    apb_slave_bank_if bus();

    apb_slave_bank #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_clr    (err_clr),
        .prot_err   (prot_err),
        .err_count  (err_count),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int W_PRDATA = 0;
    localparam int W_PERR   = 1;
    localparam int W_ERRC   = 2;
    localparam int W_XFER   = 3;

    typedef struct packed {
        int          due;
        int          which;
        logic [31:0] exp;
        int          tag;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   tag_n = 0;

    // Reference model of the status outputs, advanced by the stimulus.
    int   m_xfer = 0;
    int   m_errc = 0;
    int   m_perr = 0;

    function automatic string wname(input int which);
        case (which)
            W_PRDATA: return "Prdata";
            W_PERR:   return "prot_err";
            W_ERRC:   return "err_count";
            W_XFER:   return "xfer_count";
            default:  return "unknown";
        endcase
    endfunction

    task automatic expect_at(input int delay, input int which, input logic [31:0] val);
        exp_t e;
        e.due   = cyc + delay;
        e.which = which;
        e.exp   = val;
        e.tag   = tag_n;
        tag_n++;
        sbq.push_back(e);
    endtask

    task automatic expect_status(input int delay);
        expect_at(delay, W_PERR, 32'(m_perr));
        expect_at(delay, W_ERRC, 32'(m_errc));
        expect_at(delay, W_XFER, 32'(m_xfer & 32'hFFFF));
    endtask

    task automatic check_one(input exp_t e);
        logic [31:0] act;
        case (e.which)
            W_PRDATA: act = bus.Prdata;
            W_PERR:   act = {31'b0, prot_err};
            W_ERRC:   act = {24'b0, err_count};
            W_XFER:   act = {16'b0, xfer_count};
            default:  act = 32'hxxxx_xxxx;
        endcase
        n_vec++;
        if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s #%0d (cycle %0d): got %h, expected %h",
                     wname(e.which), e.tag, cyc, act, e.exp);
        end
    endtask

    // Monitor: retire every expectation whose cycle has arrived.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due <= cyc) begin
                check_one(sbq[i]);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.Pselx   = 3'b000;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = 32'h0;
        bus.Pwdata  = 32'h0;
    endtask

    task automatic idle_cycle();
        next_cycle();
        bus_idle();
    endtask

    task automatic apb_write(input logic [2:0] sel, input logic [31:0] addr,
                             input logic [31:0] data);
        next_cycle();
        bus.Pselx   = sel;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = addr;
        bus.Pwdata  = data;
        next_cycle();
        bus.Penable = 1'b1;
        m_xfer++;
    endtask

    task automatic apb_read(input logic [2:0] sel, input logic [31:0] addr,
                            input logic [31:0] exp);
        next_cycle();
        bus.Pselx   = sel;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = addr;
        bus.Pwdata  = 32'h0;
        next_cycle();
        bus.Penable = 1'b1;
        expect_at(0, W_PRDATA, exp);
        m_xfer++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset values, then a read of bank 0 word 5.
        expect_at(0, W_PRDATA, 32'h0);
        expect_status(0);
        apb_read(3'b001, 32'h0000_0014, 32'h0);
        idle_cycle();
        expect_status(0);

        // Single write then read.
        apb_write(3'b010, 32'h8400_0014, 32'hDEAD_BEEF);
        idle_cycle();
        apb_read(3'b010, 32'h8400_0014, 32'hDEAD_BEEF);
        idle_cycle();
        expect_status(0);

        // Back-to-back write -> read, other banks untouched.
        apb_write(3'b100, 32'h0000_000C, 32'h1234_5678);
        apb_read(3'b100, 32'h0000_000C, 32'h1234_5678);
        apb_read(3'b001, 32'h0000_000C, 32'h0);
        apb_read(3'b010, 32'h0000_000C, 32'h0);
        idle_cycle();
        expect_status(0);

        // Penable without a SETUP from IDLE.
        next_cycle();
        bus.Pselx   = 3'b001;
        bus.Penable = 1'b1;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h0;
        bus.Pwdata  = 32'hFFFF_FFFF;
        m_perr = 1;
        m_errc = 1;
        expect_status(1);
        idle_cycle();
        apb_read(3'b001, 32'h0000_0000, 32'h0);
        idle_cycle();
        expect_status(0);

        // Multi-hot select held for 300 cycles: count saturates, no write.
        next_cycle();
        bus.Pselx   = 3'b011;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h0;
        bus.Pwdata  = 32'hA5A5_A5A5;
        expect_at(1, W_ERRC, 32'd2);
        repeat (299) next_cycle();
        m_errc = 255;
        expect_status(1);
        idle_cycle();
        apb_read(3'b001, 32'h0000_0000, 32'h0);
        apb_read(3'b010, 32'h0000_0000, 32'h0);
        idle_cycle();
        expect_status(0);

        // err_clr beats a same-cycle violation; xfer_count is kept.
        next_cycle();
        bus.Pselx   = 3'b011;
        err_clr     = 1'b1;
        m_perr = 0;
        m_errc = 0;
        expect_status(1);
        next_cycle();
        err_clr = 1'b0;
        bus_idle();

        // Address change between SETUP and ACCESS.
        next_cycle();
        bus.Pselx   = 3'b001;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h0000_0004;
        bus.Pwdata  = 32'h5555_AAAA;
        next_cycle();
        bus.Penable = 1'b1;
        bus.Paddr   = 32'h0000_0008;
        m_perr = 1;
        m_errc = 1;
        expect_status(1);
        idle_cycle();
        apb_read(3'b001, 32'h0000_0004, 32'h0);
        apb_read(3'b001, 32'h0000_0008, 32'h0);
        idle_cycle();
        expect_status(0);

        // Reset asserted while a write sits in SETUP.
        apb_read(3'b010, 32'h0000_0014, 32'hDEAD_BEEF);
        next_cycle();
        bus.Pselx   = 3'b010;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h0000_001C;
        bus.Pwdata  = 32'h0000_0077;
        next_cycle();
        bus.Penable = 1'b1;
        rst = 1'b0;
        m_xfer = 0;
        m_perr = 0;
        m_errc = 0;
        expect_at(0, W_PRDATA, 32'h0);
        expect_status(0);
        next_cycle();
        bus_idle();
        next_cycle();
        rst = 1'b1;
        apb_read(3'b010, 32'h0000_001C, 32'h0);
        apb_read(3'b010, 32'h0000_0014, 32'h0);
        idle_cycle();
        expect_status(0);

        repeat (3) next_cycle();
        if (sbq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
